// File: rtl/regfile_mp.sv
// Multi-port register file with two prioritised write ports and a busy scoreboard.
// Define REGFILE_MP_BYPASS_EN for same-cycle write-to-read forwarding.
module regfile_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int NUM_RD = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_RD*ADDR_W-1:0]   ra,
    output logic [NUM_RD*DATA_W-1:0]   rd,
    output logic [NUM_RD-1:0]          rbusy,
    input  logic                       we0,
    input  logic [ADDR_W-1:0]          wa0,
    input  logic [DATA_W-1:0]          wd0,
    input  logic                       we1,
    input  logic [ADDR_W-1:0]          wa1,
    input  logic [DATA_W-1:0]          wd1,
    input  logic                       bset_en,
    input  logic [ADDR_W-1:0]          bset_addr,
    input  logic [DATA_W-1:0]          pc_in,
    output logic [(2**ADDR_W)-1:0]     busy_vec
);

    localparam int unsigned NREGS = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] TOP = '1;

    // The top address is the PC and has no storage or busy bit.
    logic [DATA_W-1:0] regs [0:NREGS-2];
    logic [NREGS-2:0]  busy_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned r = 0; r < NREGS - 1; r++) begin
                regs[r] <= '0;
            end
            busy_q <= '0;
        end else begin
            for (int unsigned r = 0; r < NREGS - 1; r++) begin
                if (we1 && wa1 == ADDR_W'(r)) begin
                    regs[r] <= wd1;
                end else if (we0 && wa0 == ADDR_W'(r)) begin
                    regs[r] <= wd0;
                end
                // A new issue to r outranks a write completing to r in the same cycle.
                if (bset_en && bset_addr == ADDR_W'(r)) begin
                    busy_q[r] <= 1'b1;
                end else if ((we0 && wa0 == ADDR_W'(r)) || (we1 && wa1 == ADDR_W'(r))) begin
                    busy_q[r] <= 1'b0;
                end
            end
        end
    end

    assign busy_vec = {1'b0, busy_q};

    always_comb begin
        logic [ADDR_W-1:0] addr;
        rd    = '0;
        rbusy = '0;
        addr  = '0;
        for (int unsigned i = 0; i < NUM_RD; i++) begin
            addr = ra[i*ADDR_W +: ADDR_W];
            if (addr == TOP) begin
                rd[i*DATA_W +: DATA_W] = pc_in;
                rbusy[i]               = 1'b0;
`ifdef REGFILE_MP_BYPASS_EN
            end else if (we1 && wa1 == addr) begin
                rd[i*DATA_W +: DATA_W] = wd1;
                rbusy[i]               = 1'b0;
            end else if (we0 && wa0 == addr) begin
                rd[i*DATA_W +: DATA_W] = wd0;
                rbusy[i]               = 1'b0;
`endif
            end else begin
                rd[i*DATA_W +: DATA_W] = regs[addr];
                rbusy[i]               = busy_q[addr];
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed steps, randomized traffic against
// an array-based reference model, and a 16-bit/8-entry/3-read-port instance.
module tb_regfile_mp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [7:0]  ra;
    logic [63:0] rd;
    logic [1:0]  rbusy;
    logic        we0, we1, bset_en;
    logic [3:0]  wa0, wa1, bset_addr;
    logic [31:0] wd0, wd1, pc_in;
    logic [15:0] busy_vec;

    logic [8:0]  ra_s;
    logic [47:0] rd_s;
    logic [2:0]  rbusy_s;
    logic        we0_s;
    logic [2:0]  wa0_s;
    logic [15:0] wd0_s, pc_s;
    logic [7:0]  busy_vec_s;

    regfile_mp #(.DATA_W(32), .ADDR_W(4), .NUM_RD(2)) dut (
        .clk(clk), .reset(reset), .ra(ra), .rd(rd), .rbusy(rbusy),
        .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
        .bset_en(bset_en), .bset_addr(bset_addr), .pc_in(pc_in), .busy_vec(busy_vec)
    );

    regfile_mp #(.DATA_W(16), .ADDR_W(3), .NUM_RD(3)) dut_s (
        .clk(clk), .reset(reset), .ra(ra_s), .rd(rd_s), .rbusy(rbusy_s),
        .we0(we0_s), .wa0(wa0_s), .wd0(wd0_s), .we1(1'b0), .wa1(3'd0), .wd1(16'd0),
        .bset_en(1'b0), .bset_addr(3'd0), .pc_in(pc_s), .busy_vec(busy_vec_s)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference state: what each architectural register should hold.
    logic [31:0] m_mem [16];
    bit          m_busy [16];
    logic [15:0] ms_mem [8];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [3:0] a);
        if (a == 4'd15) return pc_in;
`ifdef REGFILE_MP_BYPASS_EN
        if (we1 && wa1 == a) return wd1;
        if (we0 && wa0 == a) return wd0;
`endif
        return m_mem[a];
    endfunction

    function automatic logic exp_rbusy(input logic [3:0] a);
        if (a == 4'd15) return 1'b0;
`ifdef REGFILE_MP_BYPASS_EN
        if ((we1 && wa1 == a) || (we0 && wa0 == a)) return 1'b0;
`endif
        return m_busy[a];
    endfunction

    function automatic logic [15:0] exp_bv();
        logic [15:0] v;
        v = '0;
        for (int r = 0; r < 15; r++) v[r] = m_busy[r];
        return v;
    endfunction

    task automatic check_all(input string tag);
        logic [3:0] a;
        for (int p = 0; p < 2; p++) begin
            a = ra[p*4 +: 4];
            chk($sformatf("%s_rd%0d_a%0d", tag, p, a), {32'd0, rd[p*32 +: 32]}, {32'd0, exp_rd(a)});
            chk($sformatf("%s_rbusy%0d_a%0d", tag, p, a), {63'd0, rbusy[p]}, {63'd0, exp_rbusy(a)});
        end
        chk($sformatf("%s_busy_vec", tag), {48'd0, busy_vec}, {48'd0, exp_bv()});
    endtask

    // Apply the architectural rules for one rising edge, then advance past it.
    task automatic tick();
        bit set, clr;
        if (reset) begin
            for (int r = 0; r < 16; r++) begin m_mem[r] = '0; m_busy[r] = 0; end
            for (int r = 0; r < 8; r++) ms_mem[r] = '0;
        end else begin
            if (we0 && wa0 != 4'd15) m_mem[wa0] = wd0;
            if (we1 && wa1 != 4'd15) m_mem[wa1] = wd1;
            for (int r = 0; r < 15; r++) begin
                set = bset_en && bset_addr == 4'(r);
                clr = (we0 && wa0 == 4'(r)) || (we1 && wa1 == 4'(r));
                if (set) m_busy[r] = 1;
                else if (clr) m_busy[r] = 0;
            end
            if (we0_s && wa0_s != 3'd7) ms_mem[wa0_s] = wd0_s;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we0 = 0; we1 = 0; bset_en = 0;
        wa0 = '0; wa1 = '0; bset_addr = '0; wd0 = '0; wd1 = '0;
    endtask

    initial begin
        logic [31:0] byp_exp;
        logic [2:0]  a3;
        logic [15:0] e16;

        idle();
        ra = '0; pc_in = '0;
        ra_s = '0; we0_s = 0; wa0_s = '0; wd0_s = '0; pc_s = '0;
        for (int r = 0; r < 16; r++) begin m_mem[r] = 'x; m_busy[r] = 0; end

        // Reset with a write pending: the write must be discarded.
        reset = 1; we0 = 1; wa0 = 4'd3; wd0 = 32'h1234_5678;
        tick(); tick();
        reset = 0; idle();
        ra = {4'd0, 4'd3}; #1;
        chk("reset_rd3", {32'd0, rd[31:0]}, 64'd0);
        chk("reset_busy_vec", {48'd0, busy_vec}, 64'd0);
        check_all("reset");

        // Basic write then read.
        we0 = 1; wa0 = 4'd1; wd0 = 32'hAAAA_AAAA;
        tick(); idle();
        ra = {4'd2, 4'd1}; #1;
        chk("basic_rd0", {32'd0, rd[31:0]}, 64'hAAAA_AAAA);
        chk("basic_rd1", {32'd0, rd[63:32]}, 64'd0);
        check_all("basic");
        pc_in = 32'hFFFF_FFFF; ra = {4'd1, 4'd15}; #1;
        chk("pc_rd0", {32'd0, rd[31:0]}, 64'hFFFF_FFFF);
        check_all("pc");

        // Collision: port 1 wins.
        we0 = 1; we1 = 1; wa0 = 4'd2; wa1 = 4'd2; wd0 = 32'h1111_1111; wd1 = 32'hABCD_1110;
        tick(); idle();
        ra = {4'd15, 4'd2}; #1;
        chk("collide_rd", {32'd0, rd[31:0]}, 64'hABCD_1110);
        check_all("collide");

        // Writes to the PC address are ignored.
        we0 = 1; wa0 = 4'd15; wd0 = 32'hDEAD_BEEF;
        tick(); idle();
        pc_in = 32'h0000_0040; ra = {4'd15, 4'd15}; #1;
        chk("pcwrite_rd0", {32'd0, rd[31:0]}, 64'h0000_0040);
        chk("pcwrite_rd1", {32'd0, rd[63:32]}, 64'h0000_0040);
        check_all("pcwrite");

        // Scoreboard set, clear, and set-beats-clear.
        bset_en = 1; bset_addr = 4'd5;
        tick(); idle();
        ra = {4'd4, 4'd5}; #1;
        chk("bset_bv5", {63'd0, busy_vec[5]}, 64'd1);
        chk("bset_rbusy0", {63'd0, rbusy[0]}, 64'd1);
        check_all("bset");
        we0 = 1; wa0 = 4'd5; wd0 = 32'h5555_0005;
        tick(); idle(); #1;
        chk("clr_bv5", {63'd0, busy_vec[5]}, 64'd0);
        check_all("clr");
        bset_en = 1; bset_addr = 4'd5; we1 = 1; wa1 = 4'd5; wd1 = 32'h5A5A_5A5A;
        tick(); idle(); #1;
        chk("setclr_bv5", {63'd0, busy_vec[5]}, 64'd1);
        chk("setclr_rd0", {32'd0, rd[31:0]}, 64'h5A5A_5A5A);
        check_all("setclr");

        // Same-cycle write and read of register 4.
`ifdef REGFILE_MP_BYPASS_EN
        byp_exp = 32'h0F0F_0F0F;
`else
        byp_exp = 32'h0000_0000;
`endif
        we0 = 1; wa0 = 4'd4; wd0 = 32'h0F0F_0F0F; ra = {4'd5, 4'd4}; #1;
        chk("bypass_rd0", {32'd0, rd[31:0]}, {32'd0, byp_exp});
        check_all("bypass");
        tick(); idle(); #1;
        chk("bypass_after", {32'd0, rd[31:0]}, 64'h0F0F_0F0F);

        // Randomized traffic with occasional reset.
        for (int n = 0; n < 400; n++) begin
            reset     = ($urandom_range(0, 63) == 0);
            we0       = $urandom_range(0, 1);
            we1       = $urandom_range(0, 1);
            bset_en   = $urandom_range(0, 1);
            wa0       = 4'($urandom);
            wa1       = ($urandom_range(0, 3) == 0) ? wa0 : 4'($urandom);
            bset_addr = ($urandom_range(0, 3) == 0) ? wa1 : 4'($urandom);
            wd0       = $urandom;
            wd1       = $urandom;
            pc_in     = $urandom;
            ra        = ($urandom_range(0, 1) == 0) ? {wa1, wa0} : 8'($urandom);
            #1;
            check_all("rand");
            tick();
        end
        reset = 0; idle();

        // Narrow, shallow, three-read-port instance.
        for (int i = 0; i < 7; i++) begin
            we0_s = 1; wa0_s = 3'(i); wd0_s = 16'h1000 * 16'(i + 1) + 16'h0A5 + 16'(i);
            tick();
        end
        we0_s = 0;
        for (int a = 0; a < 8; a++) begin
            pc_s = 16'($urandom);
            ra_s = {3'((a + 3) % 8), 3'((a + 1) % 8), 3'(a)};
            #1;
            for (int p = 0; p < 3; p++) begin
                a3  = ra_s[p*3 +: 3];
                e16 = (a3 == 3'd7) ? pc_s : ms_mem[a3];
                chk($sformatf("sweep_rd%0d_a%0d", p, a3), {48'd0, rd_s[p*16 +: 16]}, {48'd0, e16});
            end
            chk("sweep_rbusy", {61'd0, rbusy_s}, 64'd0);
            chk("sweep_busy_vec", {56'd0, busy_vec_s}, 64'd0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port register file; successor to the 16x32 two-read/one-write regfile.
- Configurable width, depth and read-port count; two prioritised write ports; a per-register busy scoreboard for pending-write tracking.
- The top address maps to the external PC input.
- Sits between decode (read/issue) and writeback in the processor datapath.

Parameters:
- DATA_W, 32, data width in bits.
- ADDR_W, 4, address width; NREGS = 2**ADDR_W registers.
- NUM_RD, 2, number of read ports (1..4).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- ra  in  NUM_RD*ADDR_W  packed read addresses; port i = ra[i*ADDR_W +: ADDR_W].
- rd  out  NUM_RD*DATA_W  packed read data; port i = rd[i*DATA_W +: DATA_W].
- rbusy  out  NUM_RD  busy flag of the register addressed by each read port.
- we0  in  1  write enable, port 0.
- wa0  in  ADDR_W  write address, port 0.
- wd0  in  DATA_W  write data, port 0.
- we1  in  1  write enable, port 1 (priority port).
- wa1  in  ADDR_W  write address, port 1.
- wd1  in  DATA_W  write data, port 1.
- bset_en  in  1  mark register bset_addr busy (instruction issued with that destination).
- bset_addr  in  ADDR_W  register to mark busy.
- pc_in  in  DATA_W  PC value returned for reads of address NREGS-1.
- busy_vec  out  NREGS  full scoreboard vector; bit NREGS-1 is always 0.

Behaviour:
- Clock is clk. Reset is synchronous, active-high, named reset. Reset is sampled only on the rising clk edge.
- Reset clears every register to 0 and every busy bit to 0.
- Reset dominates: writes and bset_en in a reset cycle are discarded.
- The register at NREGS-1 is not stored. Reads of it return pc_in combinationally, and its rbusy is 0. Writes and bset to it are ignored.
- Reads are combinational (zero latency):
  - rd[i] = reg[ra[i]], or pc_in for the top address.
  - rbusy[i] = busy[ra[i]].
  - All read ports are independent; identical addresses on several ports return identical data.
- Writes take effect at the rising edge. New data is visible on rd the cycle after the edge, unless the bypass below is enabled.
- Both write ports enabled with wa0 == wa1: only wd1 is written (port 1 wins). Different addresses: both written in the same edge.
- Scoreboard, evaluated per register r at each edge (not in reset):
  - set = bset_en && bset_addr == r.
  - clr = (we0 && wa0 == r) || (we1 && wa1 == r).
  - set only -> busy = 1.
  - clr only -> busy = 0.
  - set and clr on the same r in the same cycle -> busy = 1 (new issue supersedes the completing write).
  - neither -> hold.
- A write to a non-busy register is legal: data is written and busy stays 0.
- busy_vec mirrors the busy bits directly (registered, no combinational path from inputs).
- No X propagation: unused upper bits of packed buses are ignored only when NUM_RD is such that none are unused. All NUM_RD fields are always decoded.

Optional Feature:
- Macro: REGFILE_MP_BYPASS_EN.
- Defined: same-cycle write forwarding.
  - If ra[i] matches an enabled write address (not NREGS-1), rd[i] returns that write data combinationally; wd1 takes priority over wd0.
  - rbusy[i] for a forwarded read is 0.
- Not defined: rd[i] returns the pre-edge stored value during the write cycle; rbusy reflects the stored busy bit.
- Registered state is identical in both builds.

Test Plan:
- Reset and zero read: assert reset 2 cycles with we0=1, wa0=3, wd0=32'h1234_5678 -> after release, rd for ra=3 is 0 and busy_vec = 0.
- Basic write/read:
  - Write wa0=1, wd0=32'hAAAA_AAAA.
  - Next cycle: ra0=1, ra1=2 -> rd0=32'hAAAA_AAAA, rd1=0.
  - ra=15 with pc_in=32'hFFFF_FFFF -> rd=32'hFFFF_FFFF.
- Write-port collision:
  - we0=we1=1, wa0=wa1=2, wd0=32'h1111_1111, wd1=32'hABCD_1110 -> reg2 reads 32'hABCD_1110 next cycle.
  - Write to 15 with 32'hDEAD_BEEF -> reads of 15 still return pc_in.
- Scoreboard:
  - bset 5 -> busy_vec[5]=1, rbusy=1 for ra=5.
  - Write 5 -> busy_vec[5]=0 next cycle.
  - Same-cycle bset 5 and we1 to 5 -> busy stays 1 and data is updated.
- Bypass:
  - Same-cycle we0 to 4 with 32'h0F0F_0F0F and ra0=4.
  - With REGFILE_MP_BYPASS_EN: rd0=32'h0F0F_0F0F during that cycle.
  - Without it: rd0 shows the old value (0).
- Parameter sweep: DATA_W=16, ADDR_W=3, NUM_RD=3 -> write 7 distinct values to regs 0..6. All three ports read them back correctly; address 7 returns pc_in.
